// File: rtl/seg7_scan_pkg.sv
// seg7_scan shared types and constants.
// Digit count, segment width, blank patterns.
package seg7_scan_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;
  localparam int VAL_W      = 4 * NUM_DIGITS;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'hF;

  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [NUM_DIGITS-1:0] dp;
    logic                  lz;
  } frame_t;

endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern.
// seg[0]=a ... seg[6]=g.
module hex_to_seg7
  import seg7_scan_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg
);

  // Pure lookup, active-low segments
  always_comb begin
    seg = SEG_OFF;
    unique case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed 7-segment scanner.
// Frame-latched inputs, blanking, LZ suppress.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int REFRESH_BITS = 17,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic [VAL_W-1:0]      value,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [SEG_W-1:0]      SEG,
  output logic                  DP,
  output logic                  frame_start
);

  localparam logic [REFRESH_BITS-1:0] CNT_MAX = '1;

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              dig;
  logic                    run;
  logic                    wrap;
  logic                    load_frame;
  frame_t                  shadow;
  frame_t                  frame_in;
  frame_t                  frame_use;
  phase_e                  phase;
  logic [3:0]              nib;
  logic [SEG_W-1:0]        seg_hex;
  logic [NUM_DIGITS-1:0]   lz_mask;

  assign frame_in = {value, dp_in, blank_lz};
  assign wrap     = (cnt == CNT_MAX);

  // A fresh start shows the inputs at once;
  // otherwise the latched frame is used.
  assign load_frame = enable &&
    (!run || (wrap && dig == 2'd3));
  assign frame_use = run ? shadow : frame_in;

  generate
    if (BLANK_CYCLES == 0) begin : g_noblank
      assign phase = PH_SHOW;
    end else begin : g_blank
      localparam logic [REFRESH_BITS-1:0]
        BLANK_N = REFRESH_BITS'(BLANK_CYCLES);
      assign phase = (cnt < BLANK_N) ?
        PH_BLANK : PH_SHOW;
    end
  endgenerate

  // Digits blanked while all higher ones are zero
  always_comb begin
    lz_mask = '0;
    if (frame_use.lz) begin
      lz_mask[3] = (frame_use.value[15:12] == 4'h0);
      lz_mask[2] = lz_mask[3] &&
        (frame_use.value[11:8] == 4'h0);
      lz_mask[1] = lz_mask[2] &&
        (frame_use.value[7:4] == 4'h0);
    end
  end

  assign nib = frame_use.value[{dig, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .hex (nib),
    .seg (seg_hex)
  );

  // Dwell counter and digit index
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
      dig <= '0;
      run <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      dig <= '0;
      run <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      run <= 1'b1;
      if (wrap) dig <= dig + 1'b1;
    end
  end

  // Frame shadow registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      shadow <= '0;
    end else if (load_frame) begin
      shadow <= frame_in;
    end
  end

  // Registered display drive
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      AN          <= AN_OFF;
      SEG         <= SEG_OFF;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else if (!enable) begin
      AN          <= AN_OFF;
      SEG         <= SEG_OFF;
      DP          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (dig == 2'd0) &&
        (cnt == '0);
      if (phase == PH_BLANK) begin
        AN  <= AN_OFF;
        SEG <= SEG_OFF;
        DP  <= 1'b1;
      end else begin
        AN  <= ~(4'b0001 << dig);
        SEG <= lz_mask[dig] ? SEG_OFF : seg_hex;
        DP  <= ~frame_use.dp[dig];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// seg7_scan bench: random and directed stimulus,
// frame-level reference model, queued checking.
module tb_seg7_scan;

  localparam int D     = 16;
  localparam int FRAME = 4 * D;
  localparam logic [12:0] OFF =
    {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        CLK;
  logic        RESET;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fs_a, fs_b;

  seg7_scan #(.REFRESH_BITS(4), .BLANK_CYCLES(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .enable(enable),
    .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .AN(an_a), .SEG(seg_a),
    .DP(dp_a), .frame_start(fs_a)
  );

  seg7_scan #(.REFRESH_BITS(4), .BLANK_CYCLES(0)) u_nob (
    .CLK(CLK), .RESET(RESET), .enable(enable),
    .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .AN(an_b), .SEG(seg_b),
    .DP(dp_b), .frame_start(fs_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int fails = 0;

  // active-high gfedcba for hex digits
  logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71};

  logic [12:0] qa[$];
  logic [12:0] qb[$];

  // staged inputs
  logic        s_rst, s_en, s_lz;
  logic [15:0] s_val;
  logic [3:0]  s_dp;

  // model: frame position shown at next edge
  int          p;
  logic [15:0] fv, nv;
  logic [3:0]  fdp, ndp;
  logic        flz, nlz;

  task automatic chk(input string nm,
                     input logic [12:0] act,
                     input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got AN=%b SEG=%h DP=%b fs=%b want AN=%b SEG=%h DP=%b fs=%b",
        nm, $time, act[12:9], act[8:2], act[1], act[0],
        exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [12:0] exp_out(
      input int pos, input int blank);
    int d, c;
    logic [3:0] an;
    logic [6:0] s;
    logic [3:0] nib;
    logic lz, fs;
    d  = pos / D;
    c  = pos % D;
    fs = (pos == 0);
    if (c < blank) return {4'hF, 7'h7F, 1'b1, fs};
    an  = 4'hF ^ (4'b0001 << d);
    nib = 4'((fv >> (4 * d)) & 16'hF);
    lz  = (d > 0) && flz && ((fv >> (4 * d)) == 0);
    s   = lz ? 7'h7F : ~HEX[nib];
    return {an, s, ~fdp[d], fs};
  endfunction

  task automatic model_edge();
    if (!s_rst || !s_en) begin
      p = -1;
      qa.push_back(OFF);
      qb.push_back(OFF);
      return;
    end
    if (p < 0) begin
      p = 0;
      fv = s_val; fdp = s_dp; flz = s_lz;
    end else begin
      p = p + 1;
      if (p == FRAME) begin
        p = 0;
        fv = nv; fdp = ndp; flz = nlz;
      end
    end
    if (p == FRAME - 1) begin
      nv = s_val; ndp = s_dp; nlz = s_lz;
    end
    qa.push_back(exp_out(p, 2));
    qb.push_back(exp_out(p, 0));
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      #1;
      RESET    = s_rst;
      enable   = s_en;
      value    = s_val;
      dp_in    = s_dp;
      blank_lz = s_lz;
      model_edge();
    end
  endtask

  task automatic run_until(input int d,
                           input int cmin,
                           input int cmax);
    for (int i = 0; i < 300; i++) begin
      if (p >= 0 && p / D == d &&
          p % D >= cmin && p % D <= cmax) return;
      tick();
    end
    total++;
    fails++;
    $display("FAIL run_until d=%0d not reached", d);
  endtask

  // monitor: one output word per clock
  initial begin : monitor
    logic [12:0] e;
    forever begin
      @(negedge CLK);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("blank2", {an_a, seg_a, dp_a, fs_a}, e);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("blank0", {an_b, seg_b, dp_b, fs_b}, e);
      end
    end
  end

  initial begin
    p = -1;
    fv = '0; fdp = '0; flz = 1'b0;
    nv = '0; ndp = '0; nlz = 1'b0;
    s_rst = 1'b0; s_en = 1'b0; s_lz = 1'b0;
    s_val = '0; s_dp = '0;
    RESET = 1'b1; enable = 1'b0;
    value = '0; dp_in = '0; blank_lz = 1'b0;
    #1 RESET = 1'b0;
    #1;
    chk("reset_a", {an_a, seg_a, dp_a, fs_a}, OFF);
    chk("reset_b", {an_b, seg_b, dp_b, fs_b}, OFF);
    tick(3);

    // plain scan of 1234
    s_rst = 1'b1; s_en = 1'b1; s_val = 16'h1234;
    tick(2 * FRAME + 5);

    // change input while digit 1 is shown
    run_until(1, 0, 15);
    s_val = 16'hABCD;
    tick(FRAME + 10);

    // leading-zero suppression
    s_val = 16'h0050; s_lz = 1'b1;
    tick(2 * FRAME);
    s_val = 16'h0000;
    tick(2 * FRAME);

    // enable drop during digit 2
    s_val = 16'h9876; s_lz = 1'b0;
    tick(FRAME);
    run_until(2, 3, 10);
    s_en = 1'b0;
    tick(3);
    s_en = 1'b1;
    tick(FRAME + 4);

    // decimal points
    s_dp = 4'b0101;
    tick(2 * FRAME);

    // async reset between edges during SHOW
    run_until(1, 4, 12);
    #1;
    RESET = 1'b0;
    s_rst = 1'b0;
    qa.delete();
    qb.delete();
    p = -1;
    #1;
    chk("async_a", {an_a, seg_a, dp_a, fs_a}, OFF);
    chk("async_b", {an_b, seg_b, dp_b, fs_b}, OFF);
    tick(3);
    s_rst = 1'b1;
    tick(FRAME + 3);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0)
        s_val = 16'($urandom) >>
          (4 * $urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0)
        s_dp = 4'($urandom);
      if ($urandom_range(0, 59) == 0)
        s_lz = 1'($urandom);
      if ($urandom_range(0, 99) == 0)
        s_en = ~s_en;
      else if (!s_en && $urandom_range(0, 3) == 0)
        s_en = 1'b1;
      tick();
    end

    @(negedge CLK);
    #1;
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d/%0d left want 0",
        qa.size(), qb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      total, fails);
    $finish;
  end

endmodule
